// File: rtl/sdram_ch3_arbiter.sv
// sdram_ch3_arbiter: per-transaction arbiter for SDRAM channel 3, shared by
// the ROM loader write path and the BG2 tile-fetch read path (sdr_clk domain).
// ROM has priority during a download, but after MAX_ROM_BURST consecutive ROM
// grants with BG2 waiting, BG2 is forced one grant so fetches never starve.
// Optional build macro CH3_TIMEOUT_EN: abort a BUSY transaction after
// TIMEOUT_CYC cycles without sdr_rdy and raise the sticky err flag.
module sdram_ch3_arbiter #(
    parameter int MAX_ROM_BURST = 8,
    parameter int TIMEOUT_CYC   = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        download,
    input  logic        rom_req,
    input  logic [24:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic [1:0]  rom_be,
    output logic        rom_rdy,
    input  logic        bg2_req,
    input  logic [24:0] bg2_addr,
    output logic [15:0] bg2_dout,
    output logic        bg2_rdy,
    output logic [24:0] sdr_addr,
    output logic [15:0] sdr_din,
    output logic [1:0]  sdr_be,
    output logic        sdr_rnw,
    output logic        sdr_req,
    input  logic [15:0] sdr_dout,
    input  logic        sdr_rdy,
    output logic        err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int BW = $clog2(MAX_ROM_BURST + 1);

    logic [1:0]    state_q, state_d;
    logic          owner_bg2_q, owner_bg2_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [24:0]   sdr_addr_q, sdr_addr_d;
    logic [15:0]   sdr_din_q, sdr_din_d;
    logic [1:0]    sdr_be_q, sdr_be_d;
    logic          sdr_rnw_q, sdr_rnw_d;
    logic          sdr_req_q, sdr_req_d;
    logic          rom_rdy_q, rom_rdy_d;
    logic          bg2_rdy_q, bg2_rdy_d;
    logic [15:0]   bg2_dout_q, bg2_dout_d;

    logic rom_eligible;
    logic bg2_forced;

`ifdef CH3_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    assign err = err_q;
`else
    // The timeout length only matters when the watchdog is built in.
    logic timeout_param_unused;
    assign timeout_param_unused = |TIMEOUT_CYC;
    assign err = 1'b0;
`endif

    // ROM only competes while a download is active; BG2 takes the slot once
    // the ROM burst allowance is used up.
    assign rom_eligible = download && rom_req;
    assign bg2_forced   = bg2_req && (burst_q == BW'(MAX_ROM_BURST));

    // Next-state and payload selection for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        owner_bg2_d = owner_bg2_q;
        burst_d     = burst_q;
        sdr_addr_d  = sdr_addr_q;
        sdr_din_d   = sdr_din_q;
        sdr_be_d    = sdr_be_q;
        sdr_rnw_d   = sdr_rnw_q;
        sdr_req_d   = sdr_req_q;
        rom_rdy_d   = 1'b0;
        bg2_rdy_d   = 1'b0;
        bg2_dout_d  = bg2_dout_q;
`ifdef CH3_TIMEOUT_EN
        tmo_d       = '0;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!bg2_req) begin
                    burst_d = '0;
                end
                if (rom_eligible && !bg2_forced) begin
                    owner_bg2_d = 1'b0;
                    sdr_addr_d  = rom_addr;
                    sdr_din_d   = rom_data;
                    sdr_be_d    = rom_be;
                    sdr_rnw_d   = 1'b0;
                    sdr_req_d   = 1'b1;
                    state_d     = ST_BUSY;
                    if (bg2_req && (burst_q != BW'(MAX_ROM_BURST))) begin
                        burst_d = burst_q + 1'b1;
                    end
                end else if (bg2_req) begin
                    owner_bg2_d = 1'b1;
                    sdr_addr_d  = bg2_addr;
                    sdr_be_d    = 2'b11;
                    sdr_rnw_d   = 1'b1;
                    sdr_req_d   = 1'b1;
                    state_d     = ST_BUSY;
                    burst_d     = '0;
                end
            end
            ST_BUSY: begin
                if (sdr_rdy) begin
                    sdr_req_d = 1'b0;
                    if (owner_bg2_q) begin
                        bg2_rdy_d  = 1'b1;
                        bg2_dout_d = sdr_dout;
                    end else begin
                        rom_rdy_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
`ifdef CH3_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    sdr_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (owner_bg2_q) begin
                        bg2_rdy_d  = 1'b1;
                        bg2_dout_d = 16'hFFFF;
                    end else begin
                        rom_rdy_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_bg2_q <= 1'b0;
            burst_q     <= '0;
            sdr_addr_q  <= '0;
            sdr_din_q   <= '0;
            sdr_be_q    <= '0;
            sdr_rnw_q   <= 1'b1;
            sdr_req_q   <= 1'b0;
            rom_rdy_q   <= 1'b0;
            bg2_rdy_q   <= 1'b0;
            bg2_dout_q  <= '0;
`ifdef CH3_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_bg2_q <= owner_bg2_d;
            burst_q     <= burst_d;
            sdr_addr_q  <= sdr_addr_d;
            sdr_din_q   <= sdr_din_d;
            sdr_be_q    <= sdr_be_d;
            sdr_rnw_q   <= sdr_rnw_d;
            sdr_req_q   <= sdr_req_d;
            rom_rdy_q   <= rom_rdy_d;
            bg2_rdy_q   <= bg2_rdy_d;
            bg2_dout_q  <= bg2_dout_d;
`ifdef CH3_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign sdr_addr = sdr_addr_q;
    assign sdr_din  = sdr_din_q;
    assign sdr_be   = sdr_be_q;
    assign sdr_rnw  = sdr_rnw_q;
    assign sdr_req  = sdr_req_q;
    assign rom_rdy  = rom_rdy_q;
    assign bg2_rdy  = bg2_rdy_q;
    assign bg2_dout = bg2_dout_q;

endmodule

// File: tb/tb_sdram_ch3_arbiter.sv
// Directed testbench for sdram_ch3_arbiter (optional CH3_TIMEOUT_EN scenario
// is included when the macro is defined for the build).
module tb_sdram_ch3_arbiter;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        download = 1'b0;
    logic        rom_req = 1'b0;
    logic [24:0] rom_addr = '0;
    logic [15:0] rom_data = '0;
    logic [1:0]  rom_be = '0;
    logic        rom_rdy;
    logic        bg2_req = 1'b0;
    logic [24:0] bg2_addr = '0;
    logic [15:0] bg2_dout;
    logic        bg2_rdy;
    logic [24:0] sdr_addr;
    logic [15:0] sdr_din;
    logic [1:0]  sdr_be;
    logic        sdr_rnw;
    logic        sdr_req;
    logic [15:0] sdr_dout = '0;
    logic        sdr_rdy = 1'b0;
    logic        err;

    int total = 0;
    int bad = 0;

    sdram_ch3_arbiter #(
        .MAX_ROM_BURST(8),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .download (download),
        .rom_req  (rom_req),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_be   (rom_be),
        .rom_rdy  (rom_rdy),
        .bg2_req  (bg2_req),
        .bg2_addr (bg2_addr),
        .bg2_dout (bg2_dout),
        .bg2_rdy  (bg2_rdy),
        .sdr_addr (sdr_addr),
        .sdr_din  (sdr_din),
        .sdr_be   (sdr_be),
        .sdr_rnw  (sdr_rnw),
        .sdr_req  (sdr_req),
        .sdr_dout (sdr_dout),
        .sdr_rdy  (sdr_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] got;
        logic [63:0] exp;
        reset = 1'b1;
        tick();
        tick();
        got = {sdr_req, sdr_rnw, sdr_addr, sdr_din, sdr_be, rom_rdy, bg2_rdy, bg2_dout, err};
        exp = {1'b0, 1'b1, 25'h0, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_values got=%h expected=%h", got, exp);
        end
        reset = 1'b0;
        // stray sdr_rdy in IDLE must not produce a pulse
        sdr_rdy = 1'b1;
        tick();
        sdr_rdy = 1'b0;
        total++;
        if ({sdr_req, rom_rdy, bg2_rdy} !== 3'b000) begin
            bad++;
            $display("FAIL stray_rdy req/rom_rdy/bg2_rdy=%b expected 000", {sdr_req, rom_rdy, bg2_rdy});
        end
        $display("reset: checked reset values and stray sdr_rdy");
    endtask

    task automatic test_bg2_read();
        download = 1'b0;
        bg2_addr = 25'h0040000;
        bg2_req  = 1'b1;
        tick();
        total++;
        if ({sdr_req, sdr_rnw, sdr_be} !== 4'b1111 || sdr_addr !== 25'h0040000) begin
            bad++;
            $display("FAIL bg2_grant req=%b rnw=%b be=%b addr=%h expected 1 1 11 0040000",
                     sdr_req, sdr_rnw, sdr_be, sdr_addr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (sdr_req !== 1'b1 || bg2_rdy !== 1'b0) begin
                bad++;
                $display("FAIL bg2_hold cycle=%0d req=%b bg2_rdy=%b expected 1 0", i, sdr_req, bg2_rdy);
            end
        end
        sdr_rdy  = 1'b1;
        sdr_dout = 16'hA55A;
        tick();
        sdr_rdy  = 1'b0;
        sdr_dout = 16'h0000;
        total++;
        if (bg2_rdy !== 1'b1 || rom_rdy !== 1'b0 || bg2_dout !== 16'hA55A || sdr_req !== 1'b0) begin
            bad++;
            $display("FAIL bg2_done bg2_rdy=%b rom_rdy=%b dout=%h req=%b expected 1 0 a55a 0",
                     bg2_rdy, rom_rdy, bg2_dout, sdr_req);
        end
        bg2_req = 1'b0;
        tick();
        total++;
        if (bg2_rdy !== 1'b0 || bg2_dout !== 16'hA55A) begin
            bad++;
            $display("FAIL bg2_pulse_hold bg2_rdy=%b dout=%h expected 0 a55a", bg2_rdy, bg2_dout);
        end
        tick();
        $display("bg2_read: addr=0040000 data=%h", bg2_dout);
    endtask

    task automatic test_rom_write();
        download = 1'b1;
        rom_addr = 25'h10;
        rom_data = 16'h1234;
        rom_be   = 2'b01;
        rom_req  = 1'b1;
        total++;
        if (sdr_req !== 1'b0) begin
            bad++;
            $display("FAIL rom_pre_req sdr_req=%b expected 0", sdr_req);
        end
        tick();
        total++;
        if (sdr_req !== 1'b1 || sdr_rnw !== 1'b0 || sdr_be !== 2'b01 ||
            sdr_din !== 16'h1234 || sdr_addr !== 25'h10) begin
            bad++;
            $display("FAIL rom_grant req=%b rnw=%b be=%b din=%h addr=%h expected 1 0 01 1234 0000010",
                     sdr_req, sdr_rnw, sdr_be, sdr_din, sdr_addr);
        end
        tick();
        sdr_rdy = 1'b1;
        tick();
        sdr_rdy = 1'b0;
        total++;
        if (rom_rdy !== 1'b1 || bg2_rdy !== 1'b0 || sdr_req !== 1'b0) begin
            bad++;
            $display("FAIL rom_done rom_rdy=%b bg2_rdy=%b req=%b expected 1 0 0", rom_rdy, bg2_rdy, sdr_req);
        end
        rom_req = 1'b0;
        tick();
        total++;
        if (rom_rdy !== 1'b0) begin
            bad++;
            $display("FAIL rom_pulse_width rom_rdy=%b expected 0", rom_rdy);
        end
        tick();
        download = 1'b0;
        $display("rom_write: addr=0000010 data=1234 be=01");
    endtask

    task automatic test_burst();
        int  waited;
        bit  exp_bg2;
        logic [24:0] exp_addr;
        download = 1'b1;
        rom_addr = 25'h100;
        rom_data = 16'h5555;
        rom_be   = 2'b11;
        bg2_addr = 25'h200;
        rom_req  = 1'b1;
        bg2_req  = 1'b1;
        for (int g = 0; g < 18; g++) begin
            exp_bg2  = (g == 8) || (g == 17);
            exp_addr = exp_bg2 ? 25'h200 : 25'h100;
            waited = 0;
            while (sdr_req !== 1'b1 && waited < 10) begin
                tick();
                waited++;
            end
            total++;
            if (sdr_req !== 1'b1) begin
                bad++;
                $display("FAIL burst_grant_timeout g=%0d sdr_req=%b expected 1", g, sdr_req);
            end
            if (g > 0) begin
                total++;
                if (waited != 2) begin
                    bad++;
                    $display("FAIL burst_latency g=%0d cycles_after_rdy=%0d expected 2", g, waited);
                end
            end
            total++;
            if (sdr_rnw !== exp_bg2 || sdr_addr !== exp_addr) begin
                bad++;
                $display("FAIL burst_owner g=%0d rnw=%b addr=%h expected %b %h", g, sdr_rnw, sdr_addr, exp_bg2, exp_addr);
            end
            sdr_rdy  = 1'b1;
            sdr_dout = 16'h0100 + 16'(g);
            tick();
            sdr_rdy  = 1'b0;
            total++;
            if ({rom_rdy, bg2_rdy} !== (exp_bg2 ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL burst_rdy g=%0d rom_rdy/bg2_rdy=%b expected %b", g, {rom_rdy, bg2_rdy},
                         exp_bg2 ? 2'b01 : 2'b10);
            end
            if (exp_bg2) begin
                total++;
                if (bg2_dout !== 16'h0100 + 16'(g)) begin
                    bad++;
                    $display("FAIL burst_bg2_data g=%0d dout=%h expected %h", g, bg2_dout, 16'h0100 + 16'(g));
                end
            end
            $display("burst: grant %0d owner=%s", g, sdr_rnw ? "BG2" : "ROM");
        end
        rom_req  = 1'b0;
        bg2_req  = 1'b0;
        download = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_no_download();
        int bad_cycles;
        download = 1'b0;
        rom_req  = 1'b1;
        bg2_req  = 1'b0;
        rom_addr = 25'h77;
        bad_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            total++;
            if (sdr_req !== 1'b0 || rom_rdy !== 1'b0) begin
                bad++;
                bad_cycles++;
                $display("FAIL no_download cycle=%0d sdr_req=%b rom_rdy=%b expected 0 0", i, sdr_req, rom_rdy);
            end
        end
        $display("no_download: 50 idle cycles, %0d with activity", bad_cycles);
        // both requesting without a download: BG2 wins
        bg2_addr = 25'h0ABCDE;
        bg2_req  = 1'b1;
        tick();
        total++;
        if (sdr_req !== 1'b1 || sdr_rnw !== 1'b1 || sdr_addr !== 25'h0ABCDE) begin
            bad++;
            $display("FAIL simul_nodl_grant req=%b rnw=%b addr=%h expected 1 1 0abcde", sdr_req, sdr_rnw, sdr_addr);
        end
        sdr_rdy  = 1'b1;
        sdr_dout = 16'h1111;
        tick();
        sdr_rdy  = 1'b0;
        total++;
        if ({rom_rdy, bg2_rdy} !== 2'b01 || bg2_dout !== 16'h1111) begin
            bad++;
            $display("FAIL simul_nodl_done rom_rdy/bg2_rdy=%b dout=%h expected 01 1111", {rom_rdy, bg2_rdy}, bg2_dout);
        end
        rom_req = 1'b0;
        bg2_req = 1'b0;
        tick();
        tick();
        $display("simultaneous_no_download: BG2 served");
    endtask

    task automatic test_download_fall();
        download = 1'b1;
        rom_addr = 25'h20;
        rom_data = 16'hCAFE;
        rom_be   = 2'b10;
        rom_req  = 1'b1;
        tick();
        download = 1'b0;
        tick();
        sdr_rdy = 1'b1;
        tick();
        sdr_rdy = 1'b0;
        total++;
        if (rom_rdy !== 1'b1 || sdr_req !== 1'b0) begin
            bad++;
            $display("FAIL download_fall rom_rdy=%b req=%b expected 1 0", rom_rdy, sdr_req);
        end
        rom_req = 1'b0;
        tick();
        tick();
        $display("download_fall: ROM transaction completed");
    endtask

    task automatic test_reset_mid();
        bg2_addr = 25'h0000100;
        bg2_req  = 1'b1;
        tick();
        total++;
        if (sdr_req !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_grant sdr_req=%b expected 1", sdr_req);
        end
        reset   = 1'b1;
        bg2_req = 1'b0;
        tick();
        total++;
        if ({sdr_req, sdr_rnw, sdr_addr, sdr_din, sdr_be, rom_rdy, bg2_rdy, bg2_dout, err} !==
            {1'b0, 1'b1, 25'h0, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_values req=%b rnw=%b addr=%h din=%h be=%b rdy=%b%b dout=%h err=%b expected reset values",
                     sdr_req, sdr_rnw, sdr_addr, sdr_din, sdr_be, rom_rdy, bg2_rdy, bg2_dout, err);
        end
        reset = 1'b0;
        tick();
        tick();
        sdr_rdy  = 1'b1;
        sdr_dout = 16'h9999;
        tick();
        sdr_rdy  = 1'b0;
        total++;
        if ({sdr_req, rom_rdy, bg2_rdy} !== 3'b000 || bg2_dout !== 16'h0) begin
            bad++;
            $display("FAIL late_rdy req/rom_rdy/bg2_rdy=%b dout=%h expected 000 0000", {sdr_req, rom_rdy, bg2_rdy}, bg2_dout);
        end
        bg2_addr = 25'h0000033;
        bg2_req  = 1'b1;
        tick();
        total++;
        if (sdr_req !== 1'b1 || sdr_addr !== 25'h0000033) begin
            bad++;
            $display("FAIL post_reset_grant req=%b addr=%h expected 1 0000033", sdr_req, sdr_addr);
        end
        sdr_rdy  = 1'b1;
        sdr_dout = 16'hBEEF;
        tick();
        sdr_rdy  = 1'b0;
        total++;
        if (bg2_rdy !== 1'b1 || bg2_dout !== 16'hBEEF) begin
            bad++;
            $display("FAIL post_reset_done bg2_rdy=%b dout=%h expected 1 beef", bg2_rdy, bg2_dout);
        end
        bg2_req = 1'b0;
        tick();
        tick();
        $display("reset_mid: recovered, next BG2 read data=%h", bg2_dout);
    endtask

`ifdef CH3_TIMEOUT_EN
    task automatic test_timeout();
        bg2_addr = 25'h0000444;
        bg2_req  = 1'b1;
        tick();
        for (int i = 1; i < TMO; i++) begin
            tick();
            total++;
            if (bg2_rdy !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL timeout_early cycle=%0d bg2_rdy=%b err=%b expected 0 0", i, bg2_rdy, err);
            end
        end
        tick();
        total++;
        if (bg2_rdy !== 1'b1 || bg2_dout !== 16'hFFFF || err !== 1'b1 || sdr_req !== 1'b0) begin
            bad++;
            $display("FAIL timeout_abort bg2_rdy=%b dout=%h err=%b req=%b expected 1 ffff 1 0",
                     bg2_rdy, bg2_dout, err, sdr_req);
        end
        bg2_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky err=%b expected 1", err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear err=%b expected 0", err);
        end
        $display("timeout: BG2 read aborted after %0d cycles", TMO);
    endtask
`endif

    initial begin
        test_reset();
        test_bg2_read();
        test_rom_write();
        test_burst();
        test_no_download();
        test_download_fall();
        test_reset_mid();
`ifdef CH3_TIMEOUT_EN
        test_timeout();
`else
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_tied err=%b expected 0", err);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_ch3_arbiter.md
Name: sdram_ch3_arbiter

Overview:
- Arbitrates SDRAM channel 3 between two requesters: the ROM loader write path and the BG2 tile-fetch read path.
- Sits between rom_loader / XSleenaCore BG2 fetch and the sdram ch3 port, all in the sdr_clk domain.
- Replaces the static download-based mux: grants are sequenced per transaction, and BG2 fetches are not starved during a download.

Parameters:
- MAX_ROM_BURST, 8, consecutive ROM grants allowed while a BG2 request is pending before BG2 is forced one grant.
- TIMEOUT_CYC, 1023, cycles without sdr_rdy before abort; used only with CH3_TIMEOUT_EN.

Ports:
- clk  in  1  sdr_clk domain clock
- reset  in  1  asynchronous, active-high
- download  in  1  ROM download active (ioctl_download && ioctl_index==0)
- rom_req  in  1  ROM write request, level
- rom_addr  in  25  byte address
- rom_data  in  16  write data
- rom_be  in  2  byte enables
- rom_rdy  out  1  one-cycle completion pulse
- bg2_req  in  1  BG2 read request, level
- bg2_addr  in  25  byte address
- bg2_dout  out  16  read data, valid on bg2_rdy and held afterwards
- bg2_rdy  out  1  one-cycle completion pulse
- sdr_addr  out  25  to ch3 address (controller uses [24:1])
- sdr_din  out  16  ch3 write data
- sdr_be  out  2  ch3 byte enables
- sdr_rnw  out  1  1=read, 0=write
- sdr_req  out  1  ch3 request, level
- sdr_dout  in  16  ch3 read data
- sdr_rdy  in  1  ch3 one-cycle completion pulse
- err  out  1  sticky timeout flag

Behaviour:
- All outputs are registered.
- Reset values: sdr_req=0, sdr_rnw=1, sdr_addr=0, sdr_din=0, sdr_be=0, rom_rdy=0, bg2_rdy=0, bg2_dout=0, err=0, state=IDLE, burst counter=0.
- Requester contract: hold req and its payload stable until the matching rdy pulse; drop req the cycle after rdy or later.
- State machine IDLE / BUSY / DONE:
  - IDLE: sample requests and select an owner.
    - ROM is eligible only if download=1; otherwise rom_req is ignored.
    - Priority is ROM over BG2, except BG2 wins when bg2_req=1 and the burst counter equals MAX_ROM_BURST.
    - On grant: latch the owner's addr/data/be into sdr_*; set sdr_rnw (ROM=0, BG2=1, BG2 be=2'b11); set sdr_req=1; go to BUSY.
    - No request: stay in IDLE.
  - BUSY: hold sdr_req and the sdr_* payload.
    - On sdr_rdy: sdr_req<=0; pulse the owner's rdy for 1 cycle.
    - If the owner is BG2, bg2_dout<=sdr_dout.
    - Go to DONE.
  - DONE: one cycle, no sampling (lets the requester drop req); then go to IDLE.
- Latency: req high at cycle N (in IDLE) gives sdr_req=1 at N+1. sdr_rdy at cycle M gives owner rdy at M+1. Earliest next grant sdr_req is at M+3.
- Burst counter:
  - Increments on each ROM grant made while bg2_req=1, saturating at MAX_ROM_BURST.
  - Clears on any BG2 grant, or on any IDLE cycle with bg2_req=0.
- Simultaneous requests with download=0: BG2 is granted.
- sdr_rdy received in IDLE or DONE (stray or stale): ignored, no rdy pulse generated.
- download falls while a ROM transaction is in BUSY: the transaction completes normally.
- Reset mid-transaction: immediate return to reset values. A late sdr_rdy arriving in IDLE is ignored.
- Requester rdy outputs are never asserted in the same cycle.

Optional Feature:
- CH3_TIMEOUT_EN defined:
  - A counter runs in BUSY.
  - If no sdr_rdy within TIMEOUT_CYC cycles: sdr_req<=0, err<=1 (sticky until reset), owner rdy is pulsed, and bg2_dout<=16'hFFFF for a BG2 owner. Then go to DONE.
- CH3_TIMEOUT_EN undefined: BUSY waits indefinitely, err is tied 0, and no counter logic is synthesised.

Test Plan:
- BG2 read only, download=0, bg2_addr=25'h0040000; sdr_rdy 5 cycles after sdr_req with sdr_dout=16'hA55A -> sdr_rnw=1, sdr_addr=25'h0040000, bg2_rdy one pulse, bg2_dout=16'hA55A.
- ROM write, download=1, rom_addr=25'h10, rom_data=16'h1234, rom_be=2'b01 -> sdr_rnw=0, sdr_be=2'b01, sdr_din=16'h1234, rom_rdy one pulse; sdr_req rises exactly 1 cycle after rom_req.
- download=1, rom_req and bg2_req both continuously high -> grant sequence 8 ROM, 1 BG2, 8 ROM...; never two rdy pulses in one cycle.
- download=0 with rom_req=1 and bg2_req=0 for 50 cycles -> sdr_req stays 0, rom_rdy stays 0.
- Reset asserted while in BUSY, then sdr_rdy pulsed 2 cycles after reset release -> all outputs at reset values; no rdy pulse; next bg2_req served normally.
- CH3_TIMEOUT_EN defined, TIMEOUT_CYC=15, sdr_rdy withheld on a BG2 read -> bg2_rdy after 15 BUSY cycles, bg2_dout=16'hFFFF, err=1 held until reset.
